// File: rtl/hall_tracker.sv
// hall_tracker: BLDC rotor position from three hall inputs, with
// sync, glitch filter, direction, step period, stall and error count.
module hall_tracker #(
  parameter int COUNTER_WIDTH = 16,
  parameter int PERIOD_WIDTH  = 16,
  parameter int ERR_WIDTH     = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int DIR_INVERT    = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clr,
  input  logic [2:0]                      hall,
  output logic signed [COUNTER_WIDTH-1:0] count,
  output logic                            dir,
  output logic                            step,
  output logic [PERIOD_WIDTH-1:0]         period,
  output logic                            period_valid,
  output logic                            stall,
  output logic                            err,
  output logic [ERR_WIDTH-1:0]            err_count
);

  localparam int RW = $clog2(FILTER_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(FILTER_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] TMR_MAX = '1;
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;
  localparam bit INV = (DIR_INVERT != 0);

  logic [2:0]              sync_q [SYNC_STAGES];
  logic [2:0]              hall_s;
  logic [2:0]              cand;
  logic [RW-1:0]           run;
  logic [RW-1:0]           run_n;
  logic [2:0]              hall_f;
  logic                    f_new;
  logic [2:0]              hall_prev;
  logic [PERIOD_WIDTH-1:0] timer;

  logic eval;
  logic illegal;
  logic seed;
  logic is_fwd;
  logic is_rev;
  logic is_step;
  logic is_err;
  logic up;

  // Successor of a legal code in the forward rotation order.
  function automatic logic [2:0] fwd_of(input logic [2:0] c);
    logic [2:0] n;
    unique case (c)
      3'b101:  n = 3'b100;
      3'b100:  n = 3'b110;
      3'b110:  n = 3'b010;
      3'b010:  n = 3'b011;
      3'b011:  n = 3'b001;
      3'b001:  n = 3'b101;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  // Metastability chain on the raw pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= 3'b000;
    end else begin
      sync_q[0] <= hall;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign hall_s = sync_q[SYNC_STAGES-1];

  // Length of the current run of identical synced codes.
  always_comb begin
    run_n = run;
    if (hall_s != cand)
      run_n = RW'(1);
    else if (run < RUN_MAX)
      run_n = run + RW'(1);
  end

  // Accept a code once its run reaches the filter length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand   <= 3'b000;
      run    <= '0;
      hall_f <= 3'b000;
      f_new  <= 1'b0;
    end else begin
      cand  <= hall_s;
      run   <= run_n;
      f_new <= 1'b0;
      if (run_n >= RUN_MAX) begin
        hall_f <= hall_s;
        f_new  <= (hall_s != hall_f);
      end
    end
  end

  // Only a fresh filtered code is classified, so a stuck
  // illegal code raises a single error.
  assign eval    = f_new && (hall_f != hall_prev);
  assign illegal = (hall_f == 3'b000) || (hall_f == 3'b111);
  assign seed    = (hall_prev == 3'b000);
  assign is_fwd  = (hall_f == fwd_of(hall_prev));
  assign is_rev  = (hall_prev == fwd_of(hall_f));
  assign is_step = eval && !illegal && !seed &&
                   (is_fwd || is_rev);
  assign is_err  = eval && (illegal ||
                   (!seed && !is_fwd && !is_rev));
  assign up      = is_fwd ^ INV;
  assign stall   = (timer == TMR_MAX);

  // Position, period, error bookkeeping; clr wins on count,
  // err_count and timer but pulses still go out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hall_prev    <= 3'b000;
      count        <= '0;
      dir          <= 1'b0;
      step         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      err          <= 1'b0;
      err_count    <= '0;
      timer        <= '0;
    end else begin
      step         <= is_step;
      period_valid <= is_step;
      err          <= is_err;
      if (eval)
        hall_prev <= illegal ? 3'b000 : hall_f;
      if (is_step) begin
        dir    <= up;
        count  <= up ? count + COUNTER_WIDTH'(1)
                     : count - COUNTER_WIDTH'(1);
        period <= timer;
        timer  <= PERIOD_WIDTH'(1);
      end else if (timer != TMR_MAX) begin
        timer <= timer + PERIOD_WIDTH'(1);
      end
      if (is_err && err_count != ERR_MAX)
        err_count <= err_count + ERR_WIDTH'(1);
      if (clr) begin
        count     <= '0;
        err_count <= '0;
        timer     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hall_tracker.sv
// tb_hall_tracker: directed table, corner sequences and random
// stimulus against a rotation-index reference model.
module tb_hall_tracker;

  localparam int S = 2;
  localparam int F = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  hall = 3'b000;
  logic [15:0] count0, count1, period0, period1;
  logic        dir0, dir1, step0, step1;
  logic        pv0, pv1, stall0, stall1, err0, err1;
  logic [7:0]  errc0, errc1;

  int checks = 0;
  int errors = 0;

  logic [2:0] FWD [6] = '{3'b101, 3'b100, 3'b110,
                          3'b010, 3'b011, 3'b001};

  hall_tracker u0 (
    .clk(clk), .reset(reset), .clr(clr), .hall(hall),
    .count(count0), .dir(dir0), .step(step0),
    .period(period0), .period_valid(pv0),
    .stall(stall0), .err(err0), .err_count(errc0)
  );

  hall_tracker #(.DIR_INVERT(1)) u1 (
    .clk(clk), .reset(reset), .clr(clr), .hall(hall),
    .count(count1), .dir(dir1), .step(step1),
    .period(period1), .period_valid(pv1),
    .stall(stall1), .err(err1), .err_count(errc1)
  );

  always #5 clk = ~clk;

  logic [2:0]  q[$];
  logic [2:0]  m_f, m_prev;
  bit          m_fnew, m_dir, m_dir2, m_step, m_pv, m_err;
  logic [15:0] m_cnt, m_cnt2, m_per, m_tmr;
  logic [7:0]  m_errc;

  typedef struct {
    logic [2:0]  code;
    int          hold;
    bit          clr;
    logic [15:0] c0;
    bit          d0;
    logic [7:0]  e0;
    logic [15:0] c1;
    bit          d1;
    int          per;
  } vec_t;

  vec_t tbl[$];

  function automatic int idx(input logic [2:0] c);
    for (int i = 0; i < 6; i++)
      if (FWD[i] == c) return i;
    return -1;
  endfunction

  function automatic vec_t mk(
    input logic [2:0] code, input int hold, input bit c,
    input int c0, input bit d0, input int e0,
    input int c1, input bit d1, input int per);
    vec_t v;
    v.code = code; v.hold = hold; v.clr = c;
    v.c0 = 16'(c0); v.d0 = d0; v.e0 = 8'(e0);
    v.c1 = 16'(c1); v.d1 = d1; v.per = per;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < S + F; i++) q.push_back(3'b000);
    m_f = 0; m_prev = 0; m_fnew = 0;
    m_dir = 0; m_dir2 = 0; m_step = 0; m_pv = 0; m_err = 0;
    m_cnt = 0; m_cnt2 = 0; m_per = 0; m_tmr = 0; m_errc = 0;
  endtask

  task automatic model_step(input logic [2:0] p, input bit c);
    bit ev, stp, fw, eq;
    int d;
    ev = m_fnew && (m_f != m_prev);
    stp = 0; fw = 0; m_err = 0;
    if (ev) begin
      if (idx(m_f) < 0) begin
        m_err = 1; m_prev = 3'b000;
      end else if (m_prev == 3'b000) begin
        m_prev = m_f;
      end else begin
        d = (idx(m_f) - idx(m_prev) + 6) % 6;
        if (d == 1 || d == 5) begin
          stp = 1; fw = (d == 1);
        end else begin
          m_err = 1;
        end
        m_prev = m_f;
      end
    end
    m_step = stp; m_pv = stp;
    if (stp) begin
      m_cnt  = fw ? m_cnt + 16'd1 : m_cnt - 16'd1;
      m_cnt2 = fw ? m_cnt2 - 16'd1 : m_cnt2 + 16'd1;
      m_dir = fw; m_dir2 = !fw;
      m_per = m_tmr; m_tmr = 16'd1;
    end else if (m_tmr != 16'hFFFF) begin
      m_tmr = m_tmr + 16'd1;
    end
    if (m_err && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
    if (c) begin
      m_cnt = 0; m_cnt2 = 0; m_errc = 0; m_tmr = 0;
    end
    q.push_back(p);
    void'(q.pop_front());
    eq = 1;
    for (int i = 1; i < F; i++)
      if (q[i] != q[0]) eq = 0;
    if (eq) begin
      m_fnew = (q[0] != m_f); m_f = q[0];
    end else begin
      m_fnew = 0;
    end
  endtask

  task automatic tick();
    bit ms;
    @(posedge clk);
    model_step(hall, clr);
    @(negedge clk);
    ms = (m_tmr == 16'hFFFF);
    chk("cyc_u0",
        64'({count0, dir0, step0, period0, pv0,
             stall0, err0, errc0}),
        64'({m_cnt, m_dir, m_step, m_per, m_pv,
             ms, m_err, m_errc}));
    chk("cyc_u1",
        64'({count1, dir1, step1, period1, pv1,
             stall1, err1, errc1}),
        64'({m_cnt2, m_dir2, m_step, m_per, m_pv,
             ms, m_err, m_errc}));
  endtask

  task automatic hold(input logic [2:0] code,
                      input int n, input bit c);
    hall = code;
    clr = c;
    tick();
    clr = 1'b0;
    for (int i = 1; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("reset_u0",
        64'({count0, dir0, step0, period0, pv0,
             stall0, err0, errc0}), 64'd0);
    chk("reset_u1",
        64'({count1, dir1, step1, period1, pv1,
             stall1, err1, errc1}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] cur, nx;
    int r, h, ci;

    for (int k = 0; k <= 12; k++)
      tbl.push_back(mk(FWD[k % 6], 20, 0, k, k > 0, 0,
                       -k, 0, (k >= 2) ? 20 : -1));
    tbl.push_back(mk(3'b101, 20, 1,  0, 1, 0, 0, 0, -1));
    tbl.push_back(mk(3'b001, 20, 0, -1, 0, 0, 1, 1, -1));
    tbl.push_back(mk(3'b011, 20, 0, -2, 0, 0, 2, 1, 20));
    tbl.push_back(mk(3'b010, 20, 0, -3, 0, 0, 3, 1, 20));
    tbl.push_back(mk(3'b011,  3, 0, -3, 0, 0, 3, 1, 20));
    tbl.push_back(mk(3'b010, 20, 0, -3, 0, 0, 3, 1, 20));
    tbl.push_back(mk(3'b111, 20, 0, -3, 0, 1, 3, 1, 20));
    tbl.push_back(mk(3'b100, 20, 0, -3, 0, 1, 3, 1, 20));
    tbl.push_back(mk(3'b010, 20, 0, -3, 0, 2, 3, 1, 20));
    tbl.push_back(mk(3'b011, 20, 0, -2, 1, 2, 2, 0, -1));

    #2;
    do_reset();

    foreach (tbl[i]) begin
      hold(tbl[i].code, tbl[i].hold, tbl[i].clr);
      chk($sformatf("row%0d_count", i),
          64'(count0), 64'(tbl[i].c0));
      chk($sformatf("row%0d_dir", i),
          64'(dir0), 64'(tbl[i].d0));
      chk($sformatf("row%0d_errc", i),
          64'(errc0), 64'(tbl[i].e0));
      chk($sformatf("row%0d_count_inv", i),
          64'(count1), 64'(tbl[i].c1));
      chk($sformatf("row%0d_dir_inv", i),
          64'(dir1), 64'(tbl[i].d1));
      if (tbl[i].per >= 0)
        chk($sformatf("row%0d_period", i),
            64'(period0), 64'(tbl[i].per));
    end

    for (int i = 0; i < 300; i++)
      hold((i % 2 == 0) ? 3'b101 : 3'b010, 8, 0);
    chk("errc_sat", 64'(errc0), 64'd255);
    chk("errc_sat_inv", 64'(errc1), 64'd255);
    chk("errs_count", 64'(count0), 64'hFFFE);

    hold(3'b101, 65540, 0);
    chk("stall_hi", 64'(stall0), 64'd1);
    chk("stall_hi_inv", 64'(stall1), 64'd1);
    hold(3'b100, 20, 0);
    chk("stall_period", 64'(period0), 64'hFFFF);
    chk("stall_lo", 64'(stall0), 64'd0);
    chk("stall_count", 64'(count0), 64'hFFFF);

    hold(3'b110, 20, 0);
    hold(3'b010, 20, 0);
    chk("pre_clr_count", 64'(count0), 64'd1);
    hall = 3'b011;
    for (int i = 0; i < 6; i++) tick();
    chk("latency_pre", 64'(step0), 64'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_step", 64'(step0), 64'd1);
    chk("clr_count", 64'(count0), 64'd0);
    chk("clr_dir", 64'(dir0), 64'd1);
    chk("clr_count_inv", 64'(count1), 64'd0);
    chk("clr_errc", 64'(errc0), 64'd0);
    for (int i = 0; i < 13; i++) tick();
    hold(3'b001, 20, 0);
    chk("post_clr_count", 64'(count0), 64'd1);

    hall = 3'b101;
    for (int i = 0; i < 3; i++) tick();
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    chk("reseed_count", 64'(count0), 64'd0);
    hold(3'b100, 20, 0);
    chk("resume_count", 64'(count0), 64'd1);
    chk("resume_dir", 64'(dir0), 64'd1);

    cur = 3'b100;
    for (int s = 0; s < 200; s++) begin
      r = $urandom_range(0, 3);
      ci = idx(cur);
      if (r == 0 || ci < 0)
        nx = 3'($urandom_range(0, 7));
      else if (r == 3)
        nx = FWD[(ci + 5) % 6];
      else
        nx = FWD[(ci + 1) % 6];
      h = $urandom_range(1, 24);
      hall = nx;
      for (int i = 0; i < h; i++) begin
        clr = ($urandom_range(0, 19) == 0);
        tick();
      end
      clr = 1'b0;
      cur = nx;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
